// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StCommit,
        StRedirect
    } trap_state_e;

    typedef enum logic [1:0] {
        ExcEcall  = 2'b00,
        ExcEbreak = 2'b01,
        ExcMret   = 2'b10,
        ExcNone   = 2'b11
    } exc_type_e;

    localparam logic [3:0]  CodeMsi     = 4'd3;
    localparam logic [3:0]  CodeMti     = 4'd7;
    localparam logic [3:0]  CodeMei     = 4'd11;
    localparam logic [31:0] CauseEcall  = 32'h0000_000B;
    localparam logic [31:0] CauseEbreak = 32'h0000_0003;
    localparam logic [31:0] IrqMask     = 32'h0000_0888;
    localparam logic [31:0] IrqBit      = 32'h8000_0000;

    function automatic logic [31:0] irq_cause(input logic [3:0] code);
        return IrqBit | {28'd0, code};
    endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Signals between the trap sequencer, the pipeline, fetch and the CSR file.
interface trap_controller_if;

    logic        mstatus_mie;
    logic [31:0] mie;
    logic [31:0] mip;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        exc_valid;
    logic [1:0]  exc_type;
    logic [31:0] exc_pc;
    logic [31:0] next_pc;
    logic        drain_done;

    logic        hold_issue;
    logic        flush;
    logic        interrupt_taken;
    logic        ecall_exception;
    logic        ebreak_exception;
    logic        mret_instruction;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output mstatus_mie, mie, mip, mtvec, mepc,
        output exc_valid, exc_type, exc_pc, next_pc, drain_done,
        input  hold_issue, flush,
        input  interrupt_taken, ecall_exception, ebreak_exception, mret_instruction,
        input  trap_cause, trap_pc, redirect_valid, redirect_pc
    );

    modport slave (
        input  mstatus_mie, mie, mip, mtvec, mepc,
        input  exc_valid, exc_type, exc_pc, next_pc, drain_done,
        output hold_issue, flush,
        output interrupt_taken, ecall_exception, ebreak_exception, mret_instruction,
        output trap_cause, trap_pc, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/trap_prio_encoder.sv
// Fixed-priority pick among enabled machine interrupts: MEI > MSI > MTI.
module trap_prio_encoder
    import trap_pkg::*;
(
    input  logic [31:0] mie_i,
    input  logic [31:0] mip_i,
    output logic        valid_o,
    output logic [3:0]  code_o
);

    logic [31:0] pend;

    always_comb begin
        pend    = mie_i & mip_i & IrqMask;
        valid_o = |pend;
        if (pend[11]) begin
            code_o = CodeMei;
        end else if (pend[3]) begin
            code_o = CodeMsi;
        end else if (pend[7]) begin
            code_o = CodeMti;
        end else begin
            code_o = 4'd0;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Sequences interrupts and ecall/ebreak/mret into CSR strobes and one fetch redirect.
module trap_controller
    import trap_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input logic               clk,
    input logic               rst_n,
    trap_controller_if.slave  bus
);

    trap_state_e state_q, state_d;
    exc_type_e   type_q, type_d;
    logic        irq_q, irq_d;
    logic [3:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d;

    logic        hold_q, hold_d;
    logic        flush_q, flush_d;
    logic        int_q, int_d;
    logic        ecall_q, ecall_d;
    logic        ebreak_q, ebreak_d;
    logic        mret_q, mret_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] tpc_q, tpc_d;
    logic        redir_q, redir_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic        enc_valid;
    logic [3:0]  enc_code;
    logic        irq_eligible;
    logic        exc_accept;
    logic [31:0] vec_base;
    logic [31:0] target;

    trap_prio_encoder u_prio (
        .mie_i   (bus.mie),
        .mip_i   (bus.mip),
        .valid_o (enc_valid),
        .code_o  (enc_code)
    );

    assign irq_eligible = bus.mstatus_mie & enc_valid;
    assign exc_accept   = bus.exc_valid & (bus.exc_type != ExcNone);

    // Redirect target, evaluated while in COMMIT from the already-latched trap.
    always_comb begin
        vec_base = {bus.mtvec[31:2], 2'b00};
        if (!irq_q && (type_q == ExcMret)) begin
            target = bus.mepc;
        end else if (vec_base == 32'd0) begin
            target = RESET_VECTOR;
        end else if (irq_q && (bus.mtvec[1:0] == 2'b01)) begin
            target = vec_base + {26'd0, code_q, 2'b00};
        end else begin
            target = vec_base;
        end
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        irq_d   = irq_q;
        code_d  = code_q;
        pc_d    = pc_q;

        unique case (state_q)
            StIdle: begin
                if (exc_accept) begin
                    type_d  = exc_type_e'(bus.exc_type);
                    irq_d   = 1'b0;
                    pc_d    = bus.exc_pc;
                    state_d = StCommit;
                end else if (irq_eligible) begin
                    code_d  = enc_code;
                    irq_d   = 1'b1;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (exc_accept) begin
                    type_d  = exc_type_e'(bus.exc_type);
                    irq_d   = 1'b0;
                    pc_d    = bus.exc_pc;
                    state_d = StCommit;
                end else if (bus.drain_done) begin
                    if (irq_eligible) begin
                        code_d  = enc_code;
                        pc_d    = bus.next_pc;
                        state_d = StCommit;
                    end else begin
                        irq_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            StCommit:   state_d = StRedirect;
            StRedirect: state_d = StIdle;
            default:    state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they line up with it.
        hold_d   = (state_d != StIdle);
        flush_d  = (state_d == StCommit);
        int_d    = flush_d & irq_d;
        ecall_d  = flush_d & !irq_d & (type_d == ExcEcall);
        ebreak_d = flush_d & !irq_d & (type_d == ExcEbreak);
        mret_d   = flush_d & !irq_d & (type_d == ExcMret);
        tpc_d    = flush_d ? pc_d : 32'd0;

        cause_d = 32'd0;
        if (int_d) begin
            cause_d = irq_cause(code_d);
        end else if (ecall_d) begin
            cause_d = CauseEcall;
        end else if (ebreak_d) begin
            cause_d = CauseEbreak;
        end

        redir_d    = (state_d == StRedirect);
        redir_pc_d = redir_d ? target : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            type_q     <= ExcEcall;
            irq_q      <= 1'b0;
            code_q     <= 4'd0;
            pc_q       <= 32'd0;
            hold_q     <= 1'b0;
            flush_q    <= 1'b0;
            int_q      <= 1'b0;
            ecall_q    <= 1'b0;
            ebreak_q   <= 1'b0;
            mret_q     <= 1'b0;
            cause_q    <= 32'd0;
            tpc_q      <= 32'd0;
            redir_q    <= 1'b0;
            redir_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            irq_q      <= irq_d;
            code_q     <= code_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            flush_q    <= flush_d;
            int_q      <= int_d;
            ecall_q    <= ecall_d;
            ebreak_q   <= ebreak_d;
            mret_q     <= mret_d;
            cause_q    <= cause_d;
            tpc_q      <= tpc_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign bus.hold_issue       = hold_q;
    assign bus.flush            = flush_q;
    assign bus.interrupt_taken  = int_q;
    assign bus.ecall_exception  = ecall_q;
    assign bus.ebreak_exception = ebreak_q;
    assign bus.mret_instruction = mret_q;
    assign bus.trap_cause       = cause_q;
    assign bus.trap_pc          = tpc_q;
    assign bus.redirect_valid   = redir_q;
    assign bus.redirect_pc      = redir_pc_q;

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequencer between the pipeline and the machine-mode CSR file. Arbitrates pending machine interrupts against ecall/ebreak/mret retiring from the pipeline, drains the pipeline before taking an interrupt, and drives the CSR file's `interrupt_taken` / `ecall_exception` / `ebreak_exception` / `mret_instruction` strobes with cause and PC. It then issues one PC redirect to fetch.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, redirect target used if mtvec reads zero

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- mstatus_mie  in  1  global interrupt enable (mstatus bit 3) from CSR file
- mie  in  32  interrupt enable CSR
- mip  in  32  interrupt pending CSR (bits 3/7/11 used)
- mtvec  in  32  trap vector; [1:0] mode: 0 direct, 1 vectored, 2/3 treated as direct
- mepc  in  32  return address for mret
- exc_valid  in  1  retiring instruction is ecall/ebreak/mret
- exc_type  in  2  00 ecall, 01 ebreak, 10 mret, 11 ignored
- exc_pc  in  32  PC of the retiring instruction
- next_pc  in  32  PC of oldest unretired instruction (interrupt return point)
- drain_done  in  1  no instruction in flight past issue
- hold_issue  out  1  stop fetch/issue
- flush  out  1  kill all in-flight instructions
- interrupt_taken, ecall_exception, ebreak_exception, mret_instruction  out  1 each  one-cycle CSR strobes
- trap_cause  out  32  cause for CSR file
- trap_pc  out  32  PC for mepc
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  new fetch PC

## Operation
- Interrupt eligible: `mstatus_mie & |(mie & mip & 32'h888)`. Priority MEI (11) > MSI (3) > MTI (7). Cause = `32'h8000_0000 | code`. Exceptions: ecall 32'hB, ebreak 32'h3.
- States IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE:
  - `exc_valid` with type 00–10: latch type and `exc_pc`; go to COMMIT. Exceptions beat interrupts in the same cycle.
  - Else, if an interrupt is eligible: latch its code; go to DRAIN.
  - Type 11 is ignored.
- DRAIN:
  - `hold_issue` = 1.
  - `exc_valid` (older instruction retiring): it preempts. Latch it and go to COMMIT.
  - Else, on `drain_done`: re-evaluate eligibility.
    - Still eligible: re-latch the highest-priority code, latch `trap_pc` = `next_pc`, go to COMMIT.
    - Not eligible: go to IDLE and release hold.
- COMMIT (1 cycle):
  - `hold_issue` = 1, `flush` = 1.
  - Exactly one strobe is high, with `trap_cause` and `trap_pc` valid.
  - For mret: `trap_cause` = 0 and `trap_pc` = `exc_pc`.
- REDIRECT (1 cycle):
  - `hold_issue` = 1, `redirect_valid` = 1.
  - `redirect_pc`:
    - mret: `mepc`.
    - Trap, direct mode: `{mtvec[31:2],2'b00}`.
    - Interrupt, vectored mode: base + (code << 2), with 32-bit wrap.
    - Any trap with base 0: RESET_VECTOR.
  - Next state IDLE.
- `exc_valid` is ignored in COMMIT and REDIRECT. The pipeline is flushed, so no retire can occur there.

## Timing
- Reset: state IDLE, all outputs 0, latched type/code/PC 0. Deasserting `rst_n` mid-sequence aborts it with no strobe.
- All outputs are registered-state decodes. Strobes never assert in two consecutive cycles.
- Exception retired in cycle N:
  - COMMIT strobe in N+1.
  - CSR file updates at the end of N+1.
  - `redirect_valid` in N+2.
  - IDLE in N+3.
- Interrupt:
  - Eligible in cycle N: DRAIN from N+1.
  - `drain_done` seen in cycle M: COMMIT in M+1, REDIRECT in M+2.
  - `drain_done` already high on DRAIN entry: minimum 3 cycles from eligible to redirect.
- After mret, MIE is restored at the end of the COMMIT cycle. An interrupt can be accepted in IDLE at the earliest one cycle after REDIRECT.
- `mstatus_mie`, `mie` and `mip` are sampled only in IDLE and at `drain_done`. Changes at any other time are ignored.

## Structure
- `trap_pkg`:
  - state enum;
  - exc_type codes;
  - cause constants (MSI 3, MTI 7, MEI 11, ECALL 11, EBREAK 3);
  - IRQ mask 32'h888;
  - interrupt bit 32'h8000_0000.
- Sub-module `trap_prio_encoder`: combinational `mie & mip` to {valid, code[3:0]}, with fixed priority 11 > 3 > 7.

## Test plan
- ecall at `exc_pc` = 0x100, `mtvec` = 0x200 → next cycle: `ecall_exception` = 1, `trap_cause` = 0xB, `trap_pc` = 0x100, `flush` = 1. Following cycle: `redirect_pc` = 0x200.
- MTI and MEI both pending and enabled, `mstatus_mie` = 1, `mtvec` = 0x401 (vectored), `drain_done` after 3 cycles, `next_pc` = 0x80 → `trap_cause` = 0x8000_000B, `trap_pc` = 0x80, `redirect_pc` = 0x42C.
- Interrupt pending with `exc_valid` (ebreak) in the same IDLE cycle → `ebreak_exception` with cause 0x3; no `interrupt_taken`.
- In DRAIN, `mip` clears before `drain_done` → return to IDLE, no strobe, `hold_issue` drops.
- mret with `mepc` = 0x1234 → `mret_instruction` pulse, then `redirect_pc` = 0x1234.
- `rst_n` low during DRAIN → all outputs 0 immediately (asynchronous), no strobe; `exc_type` = 11 in IDLE produces no activity.
